// File: rtl/axi_arb_pkg.sv
// Shared types and AXI field widths for the read-channel arbiter.
package axi_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_AR, ARB_R} arb_state_e;

  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  localparam logic [BURST_W-1:0] AXI_BURST_INCR = 2'b01;
endpackage

// File: rtl/axi_rr_pick.sv
// Combinational winner picker: rotating priority starting after 'last',
// or lowest-index-wins when AXI_RD_ARB_FIXED_PRIO_EN is defined.
module axi_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] win,
  output logic             any
);
  assign any = |req;

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = N_REQ-1; i >= 0; i--)
      if (req[i]) win = IDX_W'(i);
  end
`else
  int   idx;
  logic found;

  // Walk last+1 .. last+N_REQ modulo N_REQ; first requester hit wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && req[idx]) begin
        win   = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/axi_rd_arbiter.sv
// Single-outstanding AXI4 read arbiter: N_REQ requesters share one AR/R master.
// Round-robin by default; define AXI_RD_ARB_FIXED_PRIO_EN for fixed priority.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter  int N_REQ  = 2,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int IDX_W  = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          s_arvalid,
  output logic [N_REQ-1:0]          s_arready,
  input  logic [N_REQ-1:0]          s_arid,
  input  logic [N_REQ*ADDR_W-1:0]   s_araddr,
  input  logic [N_REQ*LEN_W-1:0]    s_arlen,
  input  logic [N_REQ*SIZE_W-1:0]   s_arsize,
  input  logic [N_REQ*BURST_W-1:0]  s_arburst,
  output logic [N_REQ-1:0]          s_rvalid,
  input  logic [N_REQ-1:0]          s_rready,
  output logic [DATA_W-1:0]         s_rdata,
  output logic [RESP_W-1:0]         s_rresp,
  output logic                      s_rlast,
  output logic                      s_rid,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic                      m_arid,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [LEN_W-1:0]          m_arlen,
  output logic [SIZE_W-1:0]         m_arsize,
  output logic [BURST_W-1:0]        m_arburst,
  output logic                      m_arlock,
  output logic [3:0]                m_arcache,
  output logic [2:0]                m_arprot,
  output logic [3:0]                m_arqos,
  output logic [3:0]                m_arregion,
  output logic                      m_aruser,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [RESP_W-1:0]         m_rresp,
  input  logic                      m_rlast,
  input  logic                      m_rid,
  output logic [IDX_W-1:0]          grant,
  output logic                      busy
);
  arb_state_e          state, state_nxt;
  logic [IDX_W-1:0]    win, last_sel;
  logic                any;
  logic                take, done;

  logic                ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [LEN_W-1:0]    ar_len;
  logic [SIZE_W-1:0]   ar_size;
  logic [BURST_W-1:0]  ar_burst;

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
  assign last_sel = '0;
`else
  logic [IDX_W-1:0] last_grant;
  assign last_sel = last_grant;
`endif

  axi_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req  (s_arvalid),
    .last (last_sel),
    .win  (win),
    .any  (any)
  );

  assign take = (state == ARB_IDLE) && any;
  assign done = (state == ARB_R) && m_rvalid && m_rready && m_rlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      ar_id    <= 1'b0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        grant    <= win;
        ar_id    <= s_arid[win];
        ar_addr  <= s_araddr[int'(win)*ADDR_W +: ADDR_W];
        ar_len   <= s_arlen[int'(win)*LEN_W +: LEN_W];
        ar_size  <= s_arsize[int'(win)*SIZE_W +: SIZE_W];
        ar_burst <= s_arburst[int'(win)*BURST_W +: BURST_W];
      end
    end
  end

`ifndef AXI_RD_ARB_FIXED_PRIO_EN
  // Reset to the top index so requester 0 is first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_grant <= IDX_W'(N_REQ-1);
    else if (done) last_grant <= grant;
  end
`endif

  always_comb begin
    state_nxt = state;
    s_arready = '0;
    s_rvalid  = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    case (state)
      ARB_IDLE: begin
        // Mealy accept; gated by rst_n so all outputs are quiet during reset.
        if (any && rst_n) begin
          s_arready[win] = 1'b1;
          state_nxt      = ARB_AR;
        end
      end
      ARB_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_nxt = ARB_R;
      end
      ARB_R: begin
        s_rvalid[grant] = m_rvalid;
        m_rready        = s_rready[grant];
        if (done) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign busy      = (state != ARB_IDLE);
  assign m_arid    = ar_id;
  assign m_araddr  = ar_addr;
  assign m_arlen   = ar_len;
  assign m_arsize  = ar_size;
  assign m_arburst = ar_burst;

  assign m_arlock   = 1'b0;
  assign m_arcache  = 4'd0;
  assign m_arprot   = 3'd0;
  assign m_arqos    = 4'd0;
  assign m_arregion = 4'd0;
  assign m_aruser   = 1'b0;

  assign s_rdata = rst_n ? m_rdata : '0;
  assign s_rresp = rst_n ? m_rresp : '0;
  assign s_rlast = rst_n & m_rlast;
  assign s_rid   = rst_n & m_rid;
endmodule
